// File: rtl/ppg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ppg_pkg: shared types for the PPG channel sampler. Rev 1.0        |
// +------------------------------------------------------------------+
package ppg_pkg;

  localparam int ADC_W = 8;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_RED  = 2'd1,
    PH_IR   = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  // Both LEDs on is treated as no valid phase.
  function automatic phase_t decode_phase(input logic red, input logic ir);
    if (red && !ir)      return PH_RED;
    else if (ir && !red) return PH_IR;
    else                 return PH_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppg_channel_sampler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ppg_channel_sampler_if: ADC/strobe inputs and result outputs.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ppg_channel_sampler_if;
  logic [7:0] ADC;
  logic       LED_RED;
  logic       LED_IR;
  logic       setting_done;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  logic       red_valid;
  logic       ir_valid;
  logic [7:0] red_ac;
  logic [7:0] red_dc;
  logic [7:0] ir_ac;
  logic [7:0] ir_dc;
  logic       win_valid;
  logic [7:0] abort_cnt;

  modport master (
    output ADC, LED_RED, LED_IR, setting_done,
    input  RED_ADC_Value, IR_ADC_Value, red_valid, ir_valid,
           red_ac, red_dc, ir_ac, ir_dc, win_valid, abort_cnt
  );

  modport slave (
    input  ADC, LED_RED, LED_IR, setting_done,
    output RED_ADC_Value, IR_ADC_Value, red_valid, ir_valid,
           red_ac, red_dc, ir_ac, ir_dc, win_valid, abort_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ppg_win_stats.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ppg_win_stats: per-channel min/max/count over a window. Rev 1.0   |
// +------------------------------------------------------------------+
module ppg_win_stats
  import ppg_pkg::*;
#(
  parameter int WIN_LEN = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [ADC_W-1:0] i_sample,
  input  logic             i_sample_valid,
  input  logic             i_clear,
  output logic [ADC_W-1:0] o_min,
  output logic [ADC_W-1:0] o_max,
  output logic [7:0]       o_count,
  output logic             o_full
);

  localparam logic [7:0] c_win_len = 8'(WIN_LEN);

  logic [ADC_W-1:0] r_min;
  logic [ADC_W-1:0] r_max;
  logic [7:0]       r_count;

  assign o_full  = (r_count == c_win_len);
  assign o_min   = r_min;
  assign o_max   = r_max;
  assign o_count = r_count;

  // A full window freezes until the top closes both channels together.
  always_ff @(posedge CLK) begin
    if (rst || i_clear) begin
      r_min   <= '1;
      r_max   <= '0;
      r_count <= '0;
    end else if (i_sample_valid && !o_full) begin
      if (i_sample < r_min) r_min <= i_sample;
      if (i_sample > r_max) r_max <= i_sample;
      r_count <= r_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppg_channel_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ppg_channel_sampler: RED/IR phase averaging and AC/DC windows.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ppg_channel_sampler
  import ppg_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int AVG_LOG2   = 3,
  parameter int WIN_LEN    = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  ppg_channel_sampler_if.slave bus
);

  localparam int                 c_settle_w    = $clog2(SETTLE_CYC + 1);
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYC - 1);
  localparam logic [7:0]         c_win_len     = 8'(WIN_LEN);
  localparam int                 c_sum_w       = ADC_W + AVG_LOG2;

  state_t                r_state;
  phase_t                r_cur_phase;
  phase_t                r_last_phase;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [AVG_LOG2-1:0]   r_samp_cnt;
  logic [c_sum_w-1:0]    r_sum;

  phase_t             w_phase;
  logic [c_sum_w-1:0] w_sum_next;
  logic [ADC_W-1:0]   w_avg;
  logic               w_pub_red, w_pub_ir, w_close;
  logic [ADC_W-1:0]   w_red_min, w_red_max, w_ir_min, w_ir_max;
  logic [7:0]         w_red_count, w_ir_count;
  logic               w_red_full, w_ir_full;
  logic [ADC_W-1:0]   w_red_ac, w_red_dc, w_ir_ac, w_ir_dc;

  assign w_phase    = decode_phase(bus.LED_RED, bus.LED_IR);
  assign w_sum_next = r_sum + {{AVG_LOG2{1'b0}}, bus.ADC};
  assign w_avg      = r_sum[AVG_LOG2 +: ADC_W];
  assign w_pub_red  = (r_state == ST_PUBLISH) && bus.setting_done
                      && (r_cur_phase == PH_RED) && !w_red_full;
  assign w_pub_ir   = (r_state == ST_PUBLISH) && bus.setting_done
                      && (r_cur_phase == PH_IR) && !w_ir_full;
  assign w_close    = (w_red_count == c_win_len) && (w_ir_count == c_win_len);

  assign w_red_ac = w_red_max - w_red_min;
  assign w_red_dc = w_red_min + (w_red_ac >> 1);
  assign w_ir_ac  = w_ir_max - w_ir_min;
  assign w_ir_dc  = w_ir_min + (w_ir_ac >> 1);

  ppg_win_stats #(.WIN_LEN(WIN_LEN)) u_red_stats (
    .CLK(CLK), .rst(rst), .i_sample(w_avg), .i_sample_valid(w_pub_red),
    .i_clear(w_close), .o_min(w_red_min), .o_max(w_red_max),
    .o_count(w_red_count), .o_full(w_red_full)
  );

  ppg_win_stats #(.WIN_LEN(WIN_LEN)) u_ir_stats (
    .CLK(CLK), .rst(rst), .i_sample(w_avg), .i_sample_valid(w_pub_ir),
    .i_clear(w_close), .o_min(w_ir_min), .o_max(w_ir_max),
    .o_count(w_ir_count), .o_full(w_ir_full)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_cur_phase       <= PH_NONE;
      r_last_phase      <= PH_NONE;
      r_settle_cnt      <= '0;
      r_samp_cnt        <= '0;
      r_sum             <= '0;
      bus.RED_ADC_Value <= '0;
      bus.IR_ADC_Value  <= '0;
      bus.red_valid     <= 1'b0;
      bus.ir_valid      <= 1'b0;
      bus.red_ac        <= '0;
      bus.red_dc        <= '0;
      bus.ir_ac         <= '0;
      bus.ir_dc         <= '0;
      bus.win_valid     <= 1'b0;
      bus.abort_cnt     <= '0;
    end else begin
      bus.red_valid <= 1'b0;
      bus.ir_valid  <= 1'b0;
      bus.win_valid <= 1'b0;
      if (w_phase == PH_NONE) r_last_phase <= PH_NONE;

      if (!bus.setting_done) begin
        // An interrupted phase is not resumed; the next LED phase restarts cleanly.
        if ((r_state == ST_SETTLE || r_state == ST_ACCUM) && w_phase == r_cur_phase)
          r_last_phase <= r_cur_phase;
        r_state <= ST_IDLE;
        r_sum   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_phase != PH_NONE && w_phase != r_last_phase) begin
              r_cur_phase  <= w_phase;
              r_settle_cnt <= '0;
              r_state      <= ST_SETTLE;
            end
          end
          ST_SETTLE, ST_ACCUM: begin
            if (w_phase != r_cur_phase) begin
              if (bus.abort_cnt != 8'hFF) bus.abort_cnt <= bus.abort_cnt + 8'd1;
              r_sum <= '0;
              if (w_phase != PH_NONE) begin
                r_cur_phase  <= w_phase;
                r_settle_cnt <= '0;
                r_state      <= ST_SETTLE;
              end else begin
                r_state <= ST_IDLE;
              end
            end else if (r_state == ST_SETTLE) begin
              if (r_settle_cnt == c_settle_last) begin
                r_sum      <= '0;
                r_samp_cnt <= '0;
                r_state    <= ST_ACCUM;
              end else begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
              end
            end else begin
              r_sum      <= w_sum_next;
              r_samp_cnt <= r_samp_cnt + 1'b1;
              if (&r_samp_cnt) r_state <= ST_PUBLISH;
            end
          end
          ST_PUBLISH: begin
            if (r_cur_phase == PH_RED) begin
              bus.RED_ADC_Value <= w_avg;
              bus.red_valid     <= 1'b1;
            end else begin
              bus.IR_ADC_Value <= w_avg;
              bus.ir_valid     <= 1'b1;
            end
            r_last_phase <= r_cur_phase;
            r_state      <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (w_close) begin
        bus.red_ac    <= w_red_ac;
        bus.red_dc    <= w_red_dc;
        bus.ir_ac     <= w_ir_ac;
        bus.ir_dc     <= w_ir_dc;
        bus.win_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppg_channel_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ppg_channel_sampler: directed bench for ppg_channel_sampler.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ppg_channel_sampler;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  ppg_channel_sampler_if bus ();

  ppg_channel_sampler #(.SETTLE_CYC(8), .AVG_LOG2(3), .WIN_LEN(16)) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int red_pulses = 0, ir_pulses = 0, win_pulses = 0;
  int red_cyc = 0, ir_cyc = 0;
  int start = 0;
  int red_base = 0, ir_base = 0;

  logic [7:0] red_vals [16] = '{8'd90, 8'd130, 8'd100, 8'd110, 8'd120, 8'd95, 8'd125, 8'd105,
                                8'd90, 8'd130, 8'd100, 8'd110, 8'd120, 8'd95, 8'd125, 8'd105};

  always @(posedge CLK) begin
    cyc++;
    #1;
    if (bus.red_valid) begin red_pulses++; red_cyc = cyc; end
    if (bus.ir_valid)  begin ir_pulses++;  ir_cyc  = cyc; end
    if (bus.win_valid) win_pulses++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    bus.ADC          = 8'd200;
    bus.LED_RED      = 1'b0;
    bus.LED_IR       = 1'b0;
    bus.setting_done = 1'b0;

    // Reset held three cycles with a non-zero ADC.
    tick(3);
    check("rst_red_val", int'(bus.RED_ADC_Value), 0);
    check("rst_ir_val",  int'(bus.IR_ADC_Value), 0);
    check("rst_abort",   int'(bus.abort_cnt), 0);
    check("rst_red_ac",  int'(bus.red_ac), 0);
    check("rst_ir_dc",   int'(bus.ir_dc), 0);
    check("rst_pulses",  red_pulses + ir_pulses + win_pulses, 0);
    rst = 1'b0;
    tick(1);

    // Constant RED phase held 40 cycles: one publish, 18 cycles after the edge.
    bus.setting_done = 1'b1;
    bus.LED_RED = 1'b1;
    bus.ADC     = 8'd100;
    start       = cyc;
    tick(40);
    check("red_pulses", red_pulses, 1);
    check("red_latency", red_cyc - start, 18);
    check("red_value", int'(bus.RED_ADC_Value), 100);
    check("ir_no_pulse", ir_pulses, 0);

    // IR phase with a ramp during accumulation: (10+..+17)>>3 = 13.
    bus.LED_RED = 1'b0;
    bus.LED_IR  = 1'b1;
    bus.ADC     = 8'd0;
    start       = cyc;
    for (int j = 1; j <= 24; j++) begin
      tick(1);
      bus.ADC = (j >= 9 && j <= 16) ? 8'(j + 1) : 8'd0;
    end
    check("ir_pulses", ir_pulses, 1);
    check("ir_latency", ir_cyc - start, 18);
    check("ir_ramp_value", int'(bus.IR_ADC_Value), 13);

    // RED aborted four samples into accumulation by a switch to IR.
    bus.LED_RED = 1'b1;
    bus.LED_IR  = 1'b0;
    bus.ADC     = 8'd100;
    tick(13);
    bus.LED_RED = 1'b0;
    bus.LED_IR  = 1'b1;
    bus.ADC     = 8'd50;
    start       = cyc;
    tick(25);
    check("abort_cnt", int'(bus.abort_cnt), 1);
    check("abort_no_red", red_pulses, 1);
    check("abort_ir_pulses", ir_pulses, 2);
    check("abort_ir_latency", ir_cyc - start, 18);
    check("abort_ir_value", int'(bus.IR_ADC_Value), 50);

    // setting_done dropped mid-accumulation, then reasserted.
    bus.LED_RED = 1'b1;
    bus.LED_IR  = 1'b0;
    bus.ADC     = 8'd77;
    tick(12);
    bus.setting_done = 1'b0;
    tick(3);
    bus.setting_done = 1'b1;
    tick(20);
    check("sd_no_red", red_pulses, 1);
    check("sd_abort_same", int'(bus.abort_cnt), 1);
    check("sd_red_held", int'(bus.RED_ADC_Value), 100);
    bus.LED_RED = 1'b0;
    bus.LED_IR  = 1'b1;
    bus.ADC     = 8'd60;
    start       = cyc;
    tick(25);
    check("sd_ir_pulses", ir_pulses, 3);
    check("sd_ir_latency", ir_cyc - start, 18);
    check("sd_ir_value", int'(bus.IR_ADC_Value), 60);

    // Fresh window: 16 RED averages spanning 90..130, 16 IR at 120.
    bus.LED_IR = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("win_rst_abort", int'(bus.abort_cnt), 0);
    red_base = red_pulses;
    ir_base  = ir_pulses;
    for (int p = 0; p < 32; p++) begin
      if (p == 31) check("win_not_early", win_pulses, 0);
      bus.LED_RED = (p % 2 == 0);
      bus.LED_IR  = (p % 2 == 1);
      bus.ADC     = (p % 2 == 0) ? red_vals[p / 2] : 8'd120;
      tick(20);
    end
    bus.LED_IR = 1'b0;
    tick(5);
    check("win_red_count", red_pulses - red_base, 16);
    check("win_ir_count", ir_pulses - ir_base, 16);
    check("win_pulses", win_pulses, 1);
    check("win_red_ac", int'(bus.red_ac), 40);
    check("win_red_dc", int'(bus.red_dc), 110);
    check("win_ir_ac", int'(bus.ir_ac), 0);
    check("win_ir_dc", int'(bus.ir_dc), 120);
    check("win_last_red", int'(bus.RED_ADC_Value), 105);
    check("win_abort", int'(bus.abort_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
